dca_matrix_loadreg: RTL



---
 rtl/dca_matrix_loadreg_pkg.sv | 29 ++
 rtl/dca_matrix_row_shift_reg.sv | 62 ++++++
 rtl/dca_matrix_loadreg.sv | 91 +++++++++
 3 files changed

// File: rtl/dca_matrix_loadreg_pkg.sv
// Shared dimensions and shadow-state encoding for the matrix load register.
package dca_matrix_loadreg_pkg;

  // Shadow buffer occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } shadow_state_e;

  // Matrix dimension (rows == cols) derived from the size selector.
  function automatic int dca_matrix_dim_lpara(input int matrix_size_para);
    return (matrix_size_para < 1) ? 1 : matrix_size_para;
  endfunction

  // Scalar bit width derived from the tensor format selector.
  function automatic int dca_tensor_scalar_lpara(input int tensor_para);
    case (tensor_para)
      1:       return 16;
      2:       return 32;
      default: return 8;
    endcase
  endfunction

  // Bit width of one matrix row.
  function automatic int dca_tensor_dim_lpara(input int num_col, input int bw_scalar);
    return num_col * bw_scalar;
  endfunction

endpackage

// File: rtl/dca_matrix_row_shift_reg.sv
// Row shift register that assembles a tile from the loader's row stream,
// plus a saturating count of rows written since the last transfer.
module dca_matrix_row_shift_reg
  import dca_matrix_loadreg_pkg::*;
#(
  parameter int NUM_ROW = 4,
  parameter int BW_ROW  = 32
) (
  input  logic                      clk,
  input  logic                      rstnn,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      move_wenable,
  input  logic [BW_ROW-1:0]         move_wdata,
  input  logic                      xfer,
  output logic [NUM_ROW*BW_ROW-1:0] rows_flat,
  output logic                      count_full,
  output logic                      count_nonzero
);

  localparam int                    BW_COUNT  = $clog2(NUM_ROW + 1);
  localparam logic [BW_COUNT-1:0]   COUNT_MAX = BW_COUNT'(NUM_ROW);

  logic [NUM_ROW-1:0][BW_ROW-1:0] r_rows;
  logic [NUM_ROW-1:0][BW_ROW-1:0] w_rows_next;
  logic [BW_COUNT-1:0]            r_count;
  logic                           w_move;

  // A pending flush suppresses row movement as well as counting.
  assign w_move = ~clear & enable & move_wenable;

  // New data enters at the top row; every other row takes its upper neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROW; gi++) begin : g_row
      if (gi == NUM_ROW - 1) begin : g_top
        assign w_rows_next[gi] = move_wdata;
      end else begin : g_lower
        assign w_rows_next[gi] = r_rows[gi+1];
      end
    end
  endgenerate

  // Shift all rows by one on each move.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)      r_rows <= '0;
    else if (w_move) r_rows <= w_rows_next;
  end

  // Count rows since the last transfer; a move during a transfer starts the next tile at 1.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)                                r_count <= '0;
    else if (clear)                            r_count <= '0;
    else if (xfer)                             r_count <= w_move ? BW_COUNT'(1) : '0;
    else if (w_move && (r_count != COUNT_MAX)) r_count <= r_count + 1'b1;
  end

  assign rows_flat     = r_rows;
  assign count_full    = (r_count == COUNT_MAX);
  assign count_nonzero = (r_count != '0);

endmodule

// File: rtl/dca_matrix_loadreg.sv
// Matrix load register: shift register fed by the row loader, double-buffered
// into a shadow tile that the compute side drains through valid/ready.
module dca_matrix_loadreg
  import dca_matrix_loadreg_pkg::*;
#(
  parameter  int MATRIX_SIZE_PARA = 4,
  parameter  int TENSOR_PARA      = 0,
  localparam int MATRIX_NUM_ROW   = dca_matrix_dim_lpara(MATRIX_SIZE_PARA),
  localparam int MATRIX_NUM_COL   = dca_matrix_dim_lpara(MATRIX_SIZE_PARA),
  localparam int BW_TENSOR_SCALAR = dca_tensor_scalar_lpara(TENSOR_PARA),
  localparam int BW_TENSOR_ROW    = dca_tensor_dim_lpara(MATRIX_NUM_COL, BW_TENSOR_SCALAR),
  localparam int BW_TILE          = MATRIX_NUM_ROW * BW_TENSOR_ROW
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  output logic                     busy,
  input  logic                     mreg_move_wenable,
  input  logic [BW_TENSOR_ROW-1:0] mreg_move_wdata_list1d,
  input  logic                     loadreg_rready,
  output logic                     loadreg_rrequest,
  output logic                     matrix_rvalid,
  input  logic                     matrix_rready,
  output logic [BW_TILE-1:0]       matrix_rdata_list2d,
  output logic                     protocol_error
);

  shadow_state_e      r_state;
  shadow_state_e      w_state_next;
  logic [BW_TILE-1:0] r_shadow;
  logic               r_protocol_error;
  logic [BW_TILE-1:0] w_rows;
  logic               w_xfer;
  logic               w_count_full;
  logic               w_count_nonzero;

  dca_matrix_row_shift_reg #(
    .NUM_ROW (MATRIX_NUM_ROW),
    .BW_ROW  (BW_TENSOR_ROW)
  ) u_row_shift_reg (
    .clk           (clk),
    .rstnn         (rstnn),
    .clear         (clear),
    .enable        (enable),
    .move_wenable  (mreg_move_wenable),
    .move_wdata    (mreg_move_wdata_list1d),
    .xfer          (w_xfer),
    .rows_flat     (w_rows),
    .count_full    (w_count_full),
    .count_nonzero (w_count_nonzero)
  );

  // Accept a tile whenever the shadow is free or is being drained this same cycle;
  // a flush wins, so no tile is acknowledged while clearing.
  assign w_xfer = ~clear & enable & loadreg_rready & ((r_state == EMPTY) | matrix_rready);

  // Shadow occupancy: fill on transfer, drain on consume, stay FULL when both coincide.
  always_comb begin
    w_state_next = r_state;
    if (clear)                                              w_state_next = EMPTY;
    else if (w_xfer)                                        w_state_next = FULL;
    else if ((r_state == FULL) && enable && matrix_rready) w_state_next = EMPTY;
  end

  // Shadow state register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) r_state <= EMPTY;
    else        r_state <= w_state_next;
  end

  // Capture the pre-move shift register contents into the shadow on transfer.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)      r_shadow <= '0;
    else if (w_xfer) r_shadow <= w_rows;
  end

  // Sticky flag for tiles handed over with a wrong number of rows.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)                        r_protocol_error <= 1'b0;
    else if (clear)                    r_protocol_error <= 1'b0;
    else if (w_xfer && !w_count_full)  r_protocol_error <= 1'b1;
  end

  assign loadreg_rrequest    = w_xfer;
  assign matrix_rvalid       = (r_state == FULL);
  assign matrix_rdata_list2d = r_shadow;
  assign protocol_error      = r_protocol_error;
  assign busy                = w_count_nonzero | (r_state == FULL);

endmodule
